// File: rtl/audio_voice_regs_pkg.sv
// Shared constants and types for the AudioVoice AXI4-Lite register file.
package audio_voice_regs_pkg;
  localparam int NUM_REGS = 4;

  localparam int REG_CTRL = 0;
  localparam int REG_FREQ = 1;
  localparam int REG_VOL  = 2;
  localparam int REG_ENV  = 3;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  typedef logic [NUM_REGS-1:0][31:0] voice_regs_t;
endpackage

// File: rtl/audio_voice_byte_reg.sv
// 32-bit register with per-byte write enables and synchronous active-low reset.
module audio_voice_byte_reg (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [3:0]  strb,
  input  logic [31:0] wdata,
  output logic [31:0] q
);
  // Each byte lane updates only when the write is enabled and its strobe is set
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (we && strb[b]) q[b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end
endmodule

// File: rtl/audio_voice_axil_regs.sv
// AXI4-Lite slave holding the four AudioVoice control registers.
// Optional build macro: AUDIO_VOICE_REG_SHADOW_EN -- voice_reg_o becomes a
// shadow copy refreshed only on sample_tick, so the core sees parameter
// changes exactly at sample boundaries.
module audio_voice_axil_regs
  import audio_voice_regs_pkg::*;
#(
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 4
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  input  logic [ADDR_W-1:0] S00_AXI_AWADDR,
  input  logic [2:0]        S00_AXI_AWPROT,
  input  logic              S00_AXI_AWVALID,
  output logic              S00_AXI_AWREADY,
  input  logic [31:0]       S00_AXI_WDATA,
  input  logic [3:0]        S00_AXI_WSTRB,
  input  logic              S00_AXI_WVALID,
  output logic              S00_AXI_WREADY,
  output logic [1:0]        S00_AXI_BRESP,
  output logic              S00_AXI_BVALID,
  input  logic              S00_AXI_BREADY,
  input  logic [ADDR_W-1:0] S00_AXI_ARADDR,
  input  logic [2:0]        S00_AXI_ARPROT,
  input  logic              S00_AXI_ARVALID,
  output logic              S00_AXI_ARREADY,
  output logic [31:0]       S00_AXI_RDATA,
  output logic [1:0]        S00_AXI_RRESP,
  output logic              S00_AXI_RVALID,
  input  logic              S00_AXI_RREADY,
  input  logic              sample_tick,
  output voice_regs_t       voice_reg_o
);
  // The register map is hard-wired to four entries
  if (NUM_REGS != audio_voice_regs_pkg::NUM_REGS) begin : g_bad_num_regs
    $fatal(1, "audio_voice_axil_regs: NUM_REGS must be 4");
  end

  logic        aw_held, w_held, bvalid, rvalid;
  logic [1:0]  aw_idx_q;
  logic [31:0] wdata_q, rdata;
  logic [3:0]  wstrb_q;
  logic        aw_hs, w_hs, ar_hs, commit;
  logic [1:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  voice_regs_t regs;

  // At most one write outstanding: both channels stall while a response waits
  assign S00_AXI_AWREADY = !aw_held && !bvalid;
  assign S00_AXI_WREADY  = !w_held && !bvalid;
  assign S00_AXI_ARREADY = !rvalid;
  assign S00_AXI_BVALID  = bvalid;
  assign S00_AXI_RVALID  = rvalid;
  assign S00_AXI_RDATA   = rdata;
  assign S00_AXI_BRESP   = AXI_RESP_OKAY;
  assign S00_AXI_RRESP   = AXI_RESP_OKAY;

  assign aw_hs  = S00_AXI_AWVALID && S00_AXI_AWREADY;
  assign w_hs   = S00_AXI_WVALID && S00_AXI_WREADY;
  assign ar_hs  = S00_AXI_ARVALID && S00_AXI_ARREADY;
  assign commit = (aw_hs || aw_held) && (w_hs || w_held);

  // Commit uses the latched half if it arrived earlier, the live bus otherwise
  assign wr_idx  = aw_held ? aw_idx_q : S00_AXI_AWADDR[3:2];
  assign wr_data = w_held  ? wdata_q  : S00_AXI_WDATA;
  assign wr_strb = w_held  ? wstrb_q  : S00_AXI_WSTRB;

  // Write channel latches and response; reset drops any half-accepted write
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      bvalid   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bvalid  <= 1'b1;
    end else begin
      if (aw_hs) begin
        aw_held  <= 1'b1;
        aw_idx_q <= S00_AXI_AWADDR[3:2];
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= S00_AXI_WDATA;
        wstrb_q <= S00_AXI_WSTRB;
      end
      if (bvalid && S00_AXI_BREADY) bvalid <= 1'b0;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_reg
    audio_voice_byte_reg u_reg (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .we    (commit && (wr_idx == 2'(i))),
      .strb  (wr_strb),
      .wdata (wr_data),
      .q     (regs[i])
    );
  end

  // Read channel: registers are sampled before any same-edge write lands
  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      rvalid <= 1'b0;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= regs[S00_AXI_ARADDR[3:2]];
    end else if (rvalid && S00_AXI_RREADY) begin
      rvalid <= 1'b0;
    end
  end

`ifdef AUDIO_VOICE_REG_SHADOW_EN
  voice_regs_t shadow;

  // Shadow copy refreshed once per audio sample
  always_ff @(posedge ACLK) begin
    if (!ARESETN)         shadow <= '0;
    else if (sample_tick) shadow <= regs;
  end

  assign voice_reg_o = shadow;

  logic unused;
  assign unused = ^{S00_AXI_AWPROT, S00_AXI_ARPROT, S00_AXI_AWADDR, S00_AXI_ARADDR};
`else
  assign voice_reg_o = regs;

  logic unused;
  assign unused = ^{S00_AXI_AWPROT, S00_AXI_ARPROT, S00_AXI_AWADDR, S00_AXI_ARADDR,
                    sample_tick};
`endif
endmodule

// File: tb/tb_audio_voice_axil_regs.sv
// Randomized self-checking bench for audio_voice_axil_regs against a
// byte-array register model.
module tb_audio_voice_axil_regs;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  S00_AXI_AWADDR, S00_AXI_ARADDR;
  logic [2:0]  S00_AXI_AWPROT, S00_AXI_ARPROT;
  logic        S00_AXI_AWVALID, S00_AXI_AWREADY;
  logic [31:0] S00_AXI_WDATA;
  logic [3:0]  S00_AXI_WSTRB;
  logic        S00_AXI_WVALID, S00_AXI_WREADY;
  logic [1:0]  S00_AXI_BRESP;
  logic        S00_AXI_BVALID, S00_AXI_BREADY;
  logic        S00_AXI_ARVALID, S00_AXI_ARREADY;
  logic [31:0] S00_AXI_RDATA;
  logic [1:0]  S00_AXI_RRESP;
  logic        S00_AXI_RVALID, S00_AXI_RREADY;
  logic        sample_tick;
  logic [3:0][31:0] voice;

  // Model: four registers as bytes, plus the per-sample shadow
  logic [7:0] mem [4][4];
  logic [3:0][31:0] shadow_m;

  int n_cmp = 0;
  int n_err = 0;

  always #5 ACLK = ~ACLK;

  audio_voice_axil_regs dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S00_AXI_AWADDR(S00_AXI_AWADDR), .S00_AXI_AWPROT(S00_AXI_AWPROT),
    .S00_AXI_AWVALID(S00_AXI_AWVALID), .S00_AXI_AWREADY(S00_AXI_AWREADY),
    .S00_AXI_WDATA(S00_AXI_WDATA), .S00_AXI_WSTRB(S00_AXI_WSTRB),
    .S00_AXI_WVALID(S00_AXI_WVALID), .S00_AXI_WREADY(S00_AXI_WREADY),
    .S00_AXI_BRESP(S00_AXI_BRESP), .S00_AXI_BVALID(S00_AXI_BVALID),
    .S00_AXI_BREADY(S00_AXI_BREADY),
    .S00_AXI_ARADDR(S00_AXI_ARADDR), .S00_AXI_ARPROT(S00_AXI_ARPROT),
    .S00_AXI_ARVALID(S00_AXI_ARVALID), .S00_AXI_ARREADY(S00_AXI_ARREADY),
    .S00_AXI_RDATA(S00_AXI_RDATA), .S00_AXI_RRESP(S00_AXI_RRESP),
    .S00_AXI_RVALID(S00_AXI_RVALID), .S00_AXI_RREADY(S00_AXI_RREADY),
    .sample_tick(sample_tick), .voice_reg_o(voice)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] reg_val(input int idx);
    return {mem[idx][3], mem[idx][2], mem[idx][1], mem[idx][0]};
  endfunction

  function automatic logic [127:0] exp_voice();
    logic [3:0][31:0] v;
`ifdef AUDIO_VOICE_REG_SHADOW_EN
    v = shadow_m;
`else
    for (int i = 0; i < 4; i++) v[i] = reg_val(i);
`endif
    return v;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++)
      for (int b = 0; b < 4; b++) mem[i][b] = 8'h00;
    shadow_m = '0;
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int b = 0; b < 4; b++)
      if (strb[b]) mem[addr[3:2]][b] = data[b*8 +: 8];
  endtask

  task automatic chk_ready_all(input string tag);
    chk({tag, "_awready"}, 128'(S00_AXI_AWREADY), 128'(1));
    chk({tag, "_wready"},  128'(S00_AXI_WREADY),  128'(1));
    chk({tag, "_arready"}, 128'(S00_AXI_ARREADY), 128'(1));
  endtask

  // Full write with independent AW/W start delays and a delayed BREADY
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int awd, input int wd, input int bd);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int c = 0;
    while (!(aw_done && w_done) && c < 64) begin
      @(negedge ACLK);
      S00_AXI_AWVALID = !aw_done && (c >= awd);
      S00_AXI_AWADDR  = addr;
      S00_AXI_WVALID  = !w_done && (c >= wd);
      S00_AXI_WDATA   = data;
      S00_AXI_WSTRB   = strb;
      if (w_done && !aw_done) chk("wready_after_w", 128'(S00_AXI_WREADY), 128'(0));
      if (aw_done && !w_done) chk("awready_after_aw", 128'(S00_AXI_AWREADY), 128'(0));
      aw_hs = S00_AXI_AWVALID && S00_AXI_AWREADY;
      w_hs  = S00_AXI_WVALID && S00_AXI_WREADY;
      @(posedge ACLK);
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      c++;
    end
    @(negedge ACLK);
    S00_AXI_AWVALID = 1'b0;
    S00_AXI_WVALID  = 1'b0;
    if (!(aw_done && w_done)) chk("write_handshake_timeout", 128'(0), 128'(1));
    model_write(addr, data, strb);
    chk("bvalid_latency", 128'(S00_AXI_BVALID), 128'(1));
    chk("bresp", 128'(S00_AXI_BRESP), 128'(0));
    chk("voice_after_write", voice, exp_voice());
    for (int k = 0; k < bd; k++) begin
      S00_AXI_BREADY = 1'b0;
      chk("bvalid_hold", 128'(S00_AXI_BVALID), 128'(1));
      chk("awready_while_b", 128'(S00_AXI_AWREADY), 128'(0));
      chk("wready_while_b", 128'(S00_AXI_WREADY), 128'(0));
      @(negedge ACLK);
    end
    S00_AXI_BREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S00_AXI_BREADY = 1'b0;
    chk("bvalid_clear", 128'(S00_AXI_BVALID), 128'(0));
  endtask

  // Full read with an AR start delay and a delayed RREADY
  task automatic axi_read(input logic [3:0] addr, input int ard, input int rd);
    bit hs = 0;
    int c = 0;
    logic [31:0] exp;
    exp = reg_val(int'(addr[3:2]));
    while (!hs && c < 64) begin
      @(negedge ACLK);
      S00_AXI_ARVALID = (c >= ard);
      S00_AXI_ARADDR  = addr;
      hs = S00_AXI_ARVALID && S00_AXI_ARREADY;
      @(posedge ACLK);
      c++;
    end
    @(negedge ACLK);
    S00_AXI_ARVALID = 1'b0;
    if (!hs) chk("read_handshake_timeout", 128'(0), 128'(1));
    chk("rvalid_latency", 128'(S00_AXI_RVALID), 128'(1));
    chk("rdata", 128'(S00_AXI_RDATA), 128'(exp));
    chk("rresp", 128'(S00_AXI_RRESP), 128'(0));
    for (int k = 0; k < rd; k++) begin
      S00_AXI_RREADY = 1'b0;
      @(negedge ACLK);
      chk("rvalid_hold", 128'(S00_AXI_RVALID), 128'(1));
      chk("rdata_hold", 128'(S00_AXI_RDATA), 128'(exp));
      chk("arready_while_r", 128'(S00_AXI_ARREADY), 128'(0));
    end
    S00_AXI_RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S00_AXI_RREADY = 1'b0;
    chk("rvalid_clear", 128'(S00_AXI_RVALID), 128'(0));
  endtask

  task automatic tick();
    @(negedge ACLK);
    sample_tick = 1'b1;
    @(posedge ACLK);
    for (int i = 0; i < 4; i++) shadow_m[i] = reg_val(i);
    @(negedge ACLK);
    sample_tick = 1'b0;
    chk("voice_after_tick", voice, exp_voice());
  endtask

  // Hard stop if the bench itself wedges
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old;
    ARESETN = 1'b0;
    S00_AXI_AWADDR = '0; S00_AXI_AWPROT = '0; S00_AXI_AWVALID = 1'b0;
    S00_AXI_WDATA = '0;  S00_AXI_WSTRB = '0;  S00_AXI_WVALID = 1'b0;
    S00_AXI_BREADY = 1'b0;
    S00_AXI_ARADDR = '0; S00_AXI_ARPROT = '0; S00_AXI_ARVALID = 1'b0;
    S00_AXI_RREADY = 1'b0;
    sample_tick = 1'b0;
    model_clear();

    // Reset state
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    chk_ready_all("reset");
    chk("reset_bvalid", 128'(S00_AXI_BVALID), 128'(0));
    chk("reset_rvalid", 128'(S00_AXI_RVALID), 128'(0));
    chk("reset_rdata", 128'(S00_AXI_RDATA), 128'(0));
    chk("reset_voice", voice, 128'(0));

    // Sequential writes then reads
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0, 0);

    // W leads AW by three cycles
    axi_write(4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 0);
    axi_read(4'h8, 0, 0);
    chk("deadbeef_direct", 128'(reg_val(2)), 128'(32'hDEADBEEF));

    // Byte strobe merge
    axi_write(4'h0, 32'h00000002, 4'hF, 0, 0, 0);
    axi_write(4'h0, 32'hAABBCCDD, 4'b0010, 0, 0, 0);
    axi_read(4'h0, 0, 0);
    chk("strobe_merge", 128'(reg_val(0)), 128'(32'h0000CC02));

    // Long B backpressure followed immediately by another write
    axi_write(4'hC, 32'h12345678, 4'hF, 0, 0, 5);
    axi_write(4'h4, 32'h0BADF00D, 4'hF, 0, 0, 0);

    // Shadow holds until a sample tick
    axi_write(4'h4, 32'h00000055, 4'hF, 0, 0, 0);
`ifdef AUDIO_VOICE_REG_SHADOW_EN
    chk("shadow_before_tick", 128'(voice[1]), 128'(0));
`endif
    tick();
    chk("voice1_after_tick", 128'(voice[1]), 128'(32'h55));

    // Read and write to the same register on the same edge
    old = reg_val(1);
    @(negedge ACLK);
    S00_AXI_AWVALID = 1'b1; S00_AXI_AWADDR = 4'h5;
    S00_AXI_WVALID  = 1'b1; S00_AXI_WDATA = 32'hCAFE0001; S00_AXI_WSTRB = 4'hF;
    S00_AXI_ARVALID = 1'b1; S00_AXI_ARADDR = 4'h6;
    @(posedge ACLK);
    @(negedge ACLK);
    S00_AXI_AWVALID = 1'b0; S00_AXI_WVALID = 1'b0; S00_AXI_ARVALID = 1'b0;
    model_write(4'h4, 32'hCAFE0001, 4'hF);
    chk("same_edge_rdata_old", 128'(S00_AXI_RDATA), 128'(old));
    chk("same_edge_bvalid", 128'(S00_AXI_BVALID), 128'(1));
    chk("same_edge_rvalid", 128'(S00_AXI_RVALID), 128'(1));
    S00_AXI_BREADY = 1'b1; S00_AXI_RREADY = 1'b1;
    @(posedge ACLK);
    @(negedge ACLK);
    S00_AXI_BREADY = 1'b0; S00_AXI_RREADY = 1'b0;
    chk("same_edge_clear", 128'({S00_AXI_BVALID, S00_AXI_RVALID}), 128'(0));
    axi_read(4'h4, 0, 0);

    // Randomized mix of writes, reads and sample ticks
    for (int n = 0; n < 60; n++) begin
      int op;
      logic [3:0] a;
      op = int'($urandom_range(0, 4));
      a  = 4'($urandom);
      if (op <= 1)
        axi_write(a, $urandom, 4'($urandom), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else if (op <= 3)
        axi_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
      else
        tick();
    end

    // Reset between the AW and W handshakes
    @(negedge ACLK);
    S00_AXI_AWVALID = 1'b1; S00_AXI_AWADDR = 4'h8;
    chk("pre_reset_awready", 128'(S00_AXI_AWREADY), 128'(1));
    @(posedge ACLK);
    @(negedge ACLK);
    S00_AXI_AWVALID = 1'b0;
    ARESETN = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    ARESETN = 1'b1;
    model_clear();
    chk_ready_all("mid_reset");
    chk("mid_reset_bvalid", 128'(S00_AXI_BVALID), 128'(0));
    chk("mid_reset_voice", voice, 128'(0));
    repeat (2) @(negedge ACLK);
    chk("mid_reset_bvalid_later", 128'(S00_AXI_BVALID), 128'(0));
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
